// File: rtl/sma_mc_if.sv
// Sample/result bundle for the multi-channel moving-average filter.
// master drives samples and observes results; slave is the filter.
interface sma_mc_if #(
    parameter int DATA_W = 16,
    parameter int CH_W   = 2
);
    logic              in_valid;
    logic [CH_W-1:0]   in_ch;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [CH_W-1:0]   out_ch;
    logic [DATA_W-1:0] out_data;

    modport master (
        output in_valid,
        output in_ch,
        output in_data,
        input  out_valid,
        input  out_ch,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_ch,
        input  in_data,
        output out_valid,
        output out_ch,
        output out_data
    );
endinterface

// File: rtl/sma_mc.sv
// Multi-channel simple moving average with a runtime window of 2^L.
// Per-channel history, running sum and fill count; rounded mean out.
module sma_mc #(
    parameter int DATA_W       = 16,
    parameter int NUM_CH       = 4,
    parameter int MAX_LOG2_WIN = 4,
    parameter int SIGNED       = 0,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int CFG_W = $clog2(MAX_LOG2_WIN + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [CFG_W-1:0] cfg_log2_win,
    input  logic             clear,
    sma_mc_if.slave          bus
);
    localparam int DEPTH  = 1 << MAX_LOG2_WIN;
    localparam int SUM_W  = DATA_W + MAX_LOG2_WIN;
    localparam int FILL_W = MAX_LOG2_WIN + 1;
    localparam int PTR_W  = MAX_LOG2_WIN;
    localparam bit SGN    = (SIGNED != 0);

    localparam logic [CFG_W-1:0] WIN_MAX = CFG_W'(MAX_LOG2_WIN);
    localparam logic [CH_W:0]    CH_LIM  = (CH_W + 1)'(NUM_CH);

    logic [DATA_W-1:0] r_buf    [NUM_CH][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [NUM_CH];
    logic [FILL_W-1:0] r_fill   [NUM_CH];
    logic [SUM_W-1:0]  r_sum    [NUM_CH];
    logic [CFG_W-1:0]  r_win;

    logic              r_out_valid;
    logic [CH_W-1:0]   r_out_ch;
    logic [DATA_W-1:0] r_out_data;

    logic                    w_in_range;
    logic                    w_acc;
    logic [CH_W-1:0]         w_idx;
    logic [FILL_W-1:0]       w_n;
    logic                    w_full;
    logic [PTR_W-1:0]        w_old_ptr;
    logic [DATA_W-1:0]       w_old;
    logic [SUM_W-1:0]        w_x_ext;
    logic [SUM_W-1:0]        w_old_ext;
    logic [SUM_W-1:0]        w_sum_nxt;
    logic [SUM_W-1:0]        w_half;
    logic [SUM_W-1:0]        w_rnd;
    logic signed [SUM_W-1:0] w_rnd_s;
    logic [DATA_W-1:0]       w_mean_s;
    logic [DATA_W-1:0]       w_mean_u;
    logic [DATA_W-1:0]       w_mean;
    logic [FILL_W-1:0]       w_fill_nxt;
    logic                    w_emit;
    logic [CFG_W-1:0]        w_cfg;

    assign w_in_range = ({1'b0, bus.in_ch} < CH_LIM);
    assign w_acc      = bus.in_valid & ~clear & w_in_range;
    assign w_idx      = w_in_range ? bus.in_ch : '0;

    assign w_n       = FILL_W'(1) << r_win;
    assign w_full    = (r_fill[w_idx] == w_n);
    // N == DEPTH truncates to 0, so the oldest slot is wr_ptr itself
    assign w_old_ptr = r_wr_ptr[w_idx] - w_n[PTR_W-1:0];
    assign w_old     = w_full ? r_buf[w_idx][w_old_ptr] : '0;

    assign w_x_ext = {{MAX_LOG2_WIN{SGN & bus.in_data[DATA_W-1]}},
                      bus.in_data};
    assign w_old_ext = {{MAX_LOG2_WIN{SGN & w_old[DATA_W-1]}},
                        w_old};
    assign w_sum_nxt = r_sum[w_idx] + w_x_ext - w_old_ext;

    assign w_half = (r_win == '0) ? '0
                  : (SUM_W'(1) << (r_win - 1'b1));
    assign w_rnd    = w_sum_nxt + w_half;
    assign w_rnd_s  = w_rnd;
    assign w_mean_s = DATA_W'(w_rnd_s >>> r_win);
    assign w_mean_u = DATA_W'(w_rnd >> r_win);
    assign w_mean   = SGN ? w_mean_s : w_mean_u;

    assign w_fill_nxt = w_full ? r_fill[w_idx]
                      : r_fill[w_idx] + 1'b1;
    assign w_emit     = w_acc & (w_fill_nxt == w_n);

    assign w_cfg = (cfg_log2_win > WIN_MAX) ? WIN_MAX
                 : cfg_log2_win;

    // history is never reset: reads are gated by the fill count
    always_ff @(posedge clk) begin
        if (w_acc) begin
            r_buf[w_idx][r_wr_ptr[w_idx]] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_ptr[c] <= '0;
                r_fill[c]   <= '0;
                r_sum[c]    <= '0;
            end
            r_win       <= WIN_MAX;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_out_data  <= '0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_ch   <= w_idx;
                r_out_data <= w_mean;
            end
            if (clear) begin
                r_win <= w_cfg;
                for (int c = 0; c < NUM_CH; c++) begin
                    r_wr_ptr[c] <= '0;
                    r_fill[c]   <= '0;
                    r_sum[c]    <= '0;
                end
            end else if (w_acc) begin
                r_wr_ptr[w_idx] <= r_wr_ptr[w_idx] + 1'b1;
                r_fill[w_idx]   <= w_fill_nxt;
                r_sum[w_idx]    <= w_sum_nxt;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_sma_mc.sv
// Bench for sma_mc: an unsigned 4-channel and a signed 3-channel
// instance share one stimulus stream, checked against a window model.
`timescale 1ns/1ps
module tb_sma_mc;
    localparam int DW = 16;
    localparam int CW = 2;
    localparam int ML = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic [2:0]    cfg = '0;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_ch = '0;
    logic [DW-1:0] in_data = '0;

    always #5 clk = ~clk;

    sma_mc_if #(.DATA_W(DW), .CH_W(CW)) bus0 ();
    sma_mc_if #(.DATA_W(DW), .CH_W(CW)) bus1 ();

    assign bus0.in_valid = in_valid;
    assign bus0.in_ch    = in_ch;
    assign bus0.in_data  = in_data;
    assign bus1.in_valid = in_valid;
    assign bus1.in_ch    = in_ch;
    assign bus1.in_data  = in_data;

    sma_mc #(
        .DATA_W(DW), .NUM_CH(4),
        .MAX_LOG2_WIN(ML), .SIGNED(0)
    ) dut0 (
        .clk(clk), .rstn(rstn),
        .cfg_log2_win(cfg), .clear(clear),
        .bus(bus0)
    );

    sma_mc #(
        .DATA_W(DW), .NUM_CH(3),
        .MAX_LOG2_WIN(ML), .SIGNED(1)
    ) dut1 (
        .clk(clk), .rstn(rstn),
        .cfg_log2_win(cfg), .clear(clear),
        .bus(bus1)
    );

    int n_chk = 0;
    int n_fail = 0;
    bit run = 0;

    task automatic chk(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, got, exp, $time);
        end
    endtask

    // Model: per instance/channel list of samples since the last flush
    logic [DW-1:0] hist [8][$];
    int            m_win;
    bit            ev [2];
    logic [CW-1:0] ech [2];
    logic [DW-1:0] ed [2];

    function automatic int lim(input int k);
        return (k == 0) ? 4 : 3;
    endfunction

    function automatic longint fdiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic logic [DW-1:0] mean(input int k, input int c);
        int n;
        int sz;
        longint s;
        longint q;
        logic [DW-1:0] v;
        n = 1 << m_win;
        sz = hist[k*4+c].size();
        s = 0;
        for (int i = sz - n; i < sz; i++) begin
            v = hist[k*4+c][i];
            if (k == 1) s = s + longint'($signed(v));
            else        s = s + longint'(v);
        end
        if (m_win == 0) q = s;
        else            q = fdiv(s + n / 2, n);
        return q[DW-1:0];
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_win = ML;
            for (int i = 0; i < 8; i++) hist[i].delete();
            for (int k = 0; k < 2; k++) begin
                ev[k] = 0;
                ech[k] = '0;
                ed[k] = '0;
            end
        end else begin
            for (int k = 0; k < 2; k++) ev[k] = 0;
            if (clear) begin
                m_win = (int'(cfg) > ML) ? ML : int'(cfg);
                for (int i = 0; i < 8; i++) hist[i].delete();
            end else if (in_valid) begin
                for (int k = 0; k < 2; k++) begin
                    if (int'(in_ch) < lim(k)) begin
                        hist[k*4+in_ch].push_back(in_data);
                        if (hist[k*4+in_ch].size() > 16)
                            void'(hist[k*4+in_ch].pop_front());
                        if (hist[k*4+in_ch].size() >= (1 << m_win)) begin
                            ev[k] = 1;
                            ech[k] = in_ch;
                            ed[k] = mean(k, int'(in_ch));
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            chk("valid0", bus0.out_valid, ev[0]);
            chk("ch0", bus0.out_ch, ech[0]);
            chk("data0", bus0.out_data, ed[0]);
            chk("valid1", bus1.out_valid, ev[1]);
            chk("ch1", bus1.out_ch, ech[1]);
            chk("data1", bus1.out_data, ed[1]);
        end
    end

    task automatic send(input logic [CW-1:0] ch,
                        input logic [DW-1:0] d,
                        input bit v = 1,
                        input bit clr = 0,
                        input logic [2:0] c = 0);
        in_valid = v;
        in_ch = ch;
        in_data = d;
        clear = clr;
        cfg = c;
        @(posedge clk);
        #1;
        in_valid = 0;
        clear = 0;
    endtask

    task automatic flush(input logic [2:0] c);
        send(0, 0, 0, 1, c);
    endtask

    // Literal expectations applied to both the model and the DUT
    task automatic pin(input string nm, input int k,
                       input bit v, input logic [DW-1:0] d);
        logic ov;
        logic [DW-1:0] od;
        ov = (k == 0) ? bus0.out_valid : bus1.out_valid;
        od = (k == 0) ? bus0.out_data : bus1.out_data;
        chk({nm, "_mv"}, ev[k], v);
        chk({nm, "_dv"}, ov, v);
        if (v) begin
            chk({nm, "_md"}, ed[k], d);
            chk({nm, "_dd"}, od, d);
        end
    endtask

    initial begin
        int r;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_v0", bus0.out_valid, 0);
        chk("rst_c0", bus0.out_ch, 0);
        chk("rst_d0", bus0.out_data, 0);
        chk("rst_v1", bus1.out_valid, 0);
        chk("rst_d1", bus1.out_data, 0);
        rstn = 1;
        run = 1;

        flush(2);
        send(0, 4);
        send(0, 8);
        send(0, 12);
        pin("w4_early", 0, 0, 0);
        send(0, 16);
        pin("w4_first0", 0, 1, 10);
        pin("w4_first1", 1, 1, 10);
        chk("w4_ch", bus0.out_ch, 0);
        send(0, 20);
        pin("w4_next", 0, 1, 14);

        flush(2);
        for (int i = 0; i < 4; i++) begin
            send(0, DW'(4 * (i + 1)));
            if (i == 3) pin("il_ch0", 0, 1, 10);
            send(1, DW'(100 * (i + 1)));
            if (i == 3) begin
                pin("il_ch1", 0, 1, 250);
                chk("il_ch1_ch", bus0.out_ch, 1);
            end
        end

        flush(1);
        send(0, 1);
        send(0, 2);
        pin("rnd_u", 0, 1, 2);
        pin("rnd_s", 1, 1, 2);
        flush(1);
        send(0, 16'hFFFF);
        send(0, 16'hFFFE);
        pin("neg_u", 0, 1, 16'hFFFF);
        pin("neg_s", 1, 1, 16'hFFFF);
        flush(2);
        repeat (4) send(2, 16'h8000);
        pin("min_u", 0, 1, 16'h8000);
        pin("min_s", 1, 1, 16'h8000);

        flush(4);
        for (int i = 0; i < 40; i++) begin
            send(3, 16'hFFFF);
            chk("fs_v", bus0.out_valid, i >= 15);
            if (i == 39) pin("fs_d", 0, 1, 16'hFFFF);
        end
        send(3, 16'h0000);
        pin("fs_drop", 0, 1, 16'hEFFF);
        pin("fs_oor1", 1, 0, 0);

        flush(2);
        repeat (3) send(0, 100);
        send(0, 100, 1, 1, 7);
        pin("clr_drop", 0, 0, 0);
        for (int i = 0; i < 16; i++) begin
            send(0, 100);
            if (i < 15) chk("clr_wait", bus0.out_valid, 0);
        end
        pin("clr_first", 0, 1, 100);

        send(0, 100);
        pin("pre_rst", 0, 1, 100);
        #2;
        rstn = 0;
        #1;
        chk("arst_v0", bus0.out_valid, 0);
        chk("arst_d0", bus0.out_data, 0);
        chk("arst_v1", bus1.out_valid, 0);
        chk("arst_d1", bus1.out_data, 0);
        @(posedge clk);
        #1;
        rstn = 1;
        repeat (4) begin
            send(3, 55);
            pin("oor", 1, 0, 0);
        end
        for (int i = 0; i < 16; i++) begin
            send(0, 7);
            if (i < 15) chk("post_rst_wait", bus0.out_valid, 0);
        end
        pin("post_rst0", 0, 1, 7);
        pin("post_rst1", 1, 1, 7);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                send(CW'($urandom_range(0, 3)), DW'($urandom),
                     1'($urandom), 1, 3'($urandom_range(0, 7)));
            end else if (r < 12) begin
                send(CW'($urandom_range(0, 3)),
                     ($urandom_range(0, 1) != 0) ? 16'hFFFF
                                                 : 16'h8000);
            end else begin
                send(CW'($urandom_range(0, 3)), DW'($urandom),
                     r < 85);
            end
        end

        @(negedge clk);
        #1;
        run = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
